// File: rtl/button_conditioner.sv
// Push-button conditioner: per-channel 2-flop synchroniser, stability-counter debounce,
// press/release strobes, sticky write-one-to-clear edge capture and a maskable irq.
module button_conditioner #(
    parameter int unsigned N_BUTTONS       = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                 sys_clk_50m,
    input  logic                 sys_rst_n,
    input  logic [N_BUTTONS-1:0] buttons_raw,
    output logic [N_BUTTONS-1:0] buttons_level,
    output logic [N_BUTTONS-1:0] press_pulse,
    output logic [N_BUTTONS-1:0] release_pulse,
    output logic [N_BUTTONS-1:0] edge_capture,
    input  logic [N_BUTTONS-1:0] edge_clear,
    input  logic [N_BUTTONS-1:0] irq_mask,
    output logic                 irq
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [N_BUTTONS-1:0] IDLE_PIN = ACTIVE_LOW ? '1 : '0;

    logic [N_BUTTONS-1:0] sync1_q, sync1_d;
    logic [N_BUTTONS-1:0] sync2_q, sync2_d;
    logic [N_BUTTONS-1:0] level_q, level_d;
    logic [N_BUTTONS-1:0] press_q, press_d;
    logic [N_BUTTONS-1:0] rel_q, rel_d;
    logic [N_BUTTONS-1:0] cap_q, cap_d;
    logic                 irq_q, irq_d;
    logic [CNT_W-1:0]     cnt_q [N_BUTTONS];
    logic [CNT_W-1:0]     cnt_d [N_BUTTONS];
    logic [N_BUTTONS-1:0] pressed_c;

    // Polarity-normalised synchronised sample: 1 = pressed.
    assign pressed_c = ACTIVE_LOW ? ~sync2_q : sync2_q;

    // Debounce, strobe generation, edge capture and irq next-state.
    always_comb begin
        sync1_d = buttons_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = '0;
        rel_d   = '0;
        for (int unsigned i = 0; i < N_BUTTONS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (pressed_c[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]   = '0;
                level_d[i] = pressed_c[i];
                press_d[i] = pressed_c[i];
                rel_d[i]   = ~pressed_c[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        // A press landing together with a clear keeps the flag set.
        cap_d = (cap_q & ~edge_clear) | press_d;
        irq_d = |(cap_q & irq_mask);
    end

    always_ff @(posedge sys_clk_50m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= IDLE_PIN;
            sync2_q <= IDLE_PIN;
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
            cap_q   <= '0;
            irq_q   <= 1'b0;
            for (int unsigned i = 0; i < N_BUTTONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            cap_q   <= cap_d;
            irq_q   <= irq_d;
            for (int unsigned i = 0; i < N_BUTTONS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign buttons_level = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign edge_capture  = cap_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random pin activity, checked each
// cycle against a sliding-window reference model through an expected-value queue.
module tb_button_conditioner;

    localparam int N = 4;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] press_v;
    logic [N-1:0] buttons_raw;
    logic [N-1:0] buttons_level, press_pulse, release_pulse, edge_capture;
    logic [N-1:0] edge_clear, irq_mask;
    logic         irq;

    int n_checks = 0;
    int n_fails  = 0;

    assign buttons_raw = ~press_v;
    always #5 clk = ~clk;

    button_conditioner #(
        .N_BUTTONS(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)
    ) dut (
        .sys_clk_50m  (clk),
        .sys_rst_n    (rst_n),
        .buttons_raw  (buttons_raw),
        .buttons_level(buttons_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .edge_capture (edge_capture),
        .edge_clear   (edge_clear),
        .irq_mask     (irq_mask),
        .irq          (irq)
    );

    typedef struct {
        logic [N-1:0] level;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] cap;
        logic         irq;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: pressed samples since reset, indexed by edge number.
    bit           s_hist[N][$];
    int           t_edge;
    int           last_acc[N];
    logic [N-1:0] m_level, m_cap;
    logic         m_irq;

    function automatic bit s_at(int ch, int e);
        if (e < 2) return 1'b0;
        return s_hist[ch][e-2];
    endfunction

    always @(posedge clk) begin
        exp_t e;
        logic [N-1:0] pr, rl;
        bit ok;
        pr = '0;
        rl = '0;
        if (!rst_n) begin
            t_edge = 0;
            for (int ch = 0; ch < N; ch++) begin
                s_hist[ch].delete();
                last_acc[ch] = -1;
            end
            m_level = '0;
            m_cap   = '0;
            m_irq   = 1'b0;
        end else begin
            for (int ch = 0; ch < N; ch++) s_hist[ch].push_back(~buttons_raw[ch]);
            // Accept a new level once D consecutive samples disagree with it.
            for (int ch = 0; ch < N; ch++) begin
                if (t_edge - D + 1 > last_acc[ch]) begin
                    ok = 1'b1;
                    for (int j = 0; j < D; j++)
                        if (s_at(ch, t_edge - j) == m_level[ch]) ok = 1'b0;
                    if (ok) begin
                        m_level[ch]  = ~m_level[ch];
                        pr[ch]       = m_level[ch];
                        rl[ch]       = ~m_level[ch];
                        last_acc[ch] = t_edge;
                    end
                end
            end
            m_irq  = |(m_cap & irq_mask);
            m_cap  = (m_cap & ~edge_clear) | pr;
            t_edge = t_edge + 1;
        end
        e.level = m_level;
        e.press = pr;
        e.rel   = rl;
        e.cap   = m_cap;
        e.irq   = m_irq;
        exp_q.push_back(e);
    end

    task automatic chk(string name, logic [N-1:0] act, logic [N-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: one expected entry per clock, compared on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            if (!rst_n) begin
                e.level = '0; e.press = '0; e.rel = '0; e.cap = '0; e.irq = 1'b0;
            end
            chk("buttons_level", buttons_level, e.level);
            chk("press_pulse", press_pulse, e.press);
            chk("release_pulse", release_pulse, e.rel);
            chk("edge_capture", edge_capture, e.cap);
            chk("irq", N'(irq), N'(e.irq));
            chk("press_release_overlap", press_pulse & release_pulse, '0);
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_pulse(logic [N-1:0] bits);
        edge_clear = bits;
        step(1);
        edge_clear = '0;
    endtask

    initial begin
        rst_n = 1'b0; press_v = '0; edge_clear = '0; irq_mask = '0;
        step(3);
        rst_n = 1'b1;
        step(3);

        // Clean press on channel 0.
        irq_mask = 4'b0001;
        press_v[0] = 1'b1;
        step(15);

        // Glitch on channel 1, then a press exactly D cycles long.
        press_v[1] = 1'b1; step(5);
        press_v[1] = 1'b0; step(12);
        press_v[1] = 1'b1; step(D);
        press_v[1] = 1'b0; step(14);

        // Bounce on channel 2, then settle pressed.
        for (int i = 0; i < 10; i++) begin
            press_v[2] = ~press_v[2];
            step(3);
        end
        press_v[2] = 1'b1; step(15);
        press_v[2] = 1'b0; step(14);

        // Release and clear on channel 3, then clear overlapping a new press.
        irq_mask = 4'b1000;
        press_v[3] = 1'b1; step(12);
        press_v[3] = 1'b0; step(12);
        clear_pulse(4'b1000); step(3);
        press_v[3] = 1'b1; step(5);
        edge_clear = 4'b1000; step(7);
        edge_clear = '0; step(4);
        press_v[3] = 1'b0; step(12);
        clear_pulse(4'b1111); step(4);

        // Masking and concurrency on channels 0 and 2.
        press_v = '0; step(12);
        clear_pulse(4'b1111); step(2);
        irq_mask = 4'b0100;
        press_v = 4'b0101; step(13);
        clear_pulse(4'b0100); step(4);
        press_v = '0; step(12);

        // Reset asserted mid-debounce with channel 0 held.
        press_v[0] = 1'b1; step(7);
        rst_n = 1'b0; step(3);
        rst_n = 1'b1; step(15);
        press_v = '0; step(12);

        // Random pin activity, clears and mask changes.
        for (int i = 0; i < 600; i++) begin
            step(1);
            for (int ch = 0; ch < N; ch++)
                if ($urandom_range(0, 9) == 0) press_v[ch] = ~press_v[ch];
            edge_clear = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 31) == 0) irq_mask = N'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0; step(2); rst_n = 1'b1;
            end
        end
        edge_clear = '0;
        step(3);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
